// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Imported by the divider top and its step datapath.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DIV_MAX_N = 128;

    // All-ones quotient reported for a zero divisor; callers size-cast to N bits.
    function automatic logic [DIV_MAX_N-1:0] DIV0_QUOTIENT(input int unsigned n);
        return {DIV_MAX_N{1'b1}} >> (DIV_MAX_N - n);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand and result handshake bundle for seq_divider.
// A transfer happens on a rising edge where valid and ready are both 1; valid
// never waits for ready, ready may depend only on the receiver's own state, and
// the payload must be stable from the edge that raises valid until it transfers.
interface seq_divider_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it is non-negative.
module div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] r,
    input  logic         next_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_next,
    output logic         q_bit
);
    logic [N:0] r_shift;
    logic [N:0] trial;

    always_comb begin
        r_shift = {r, next_bit};
        trial   = r_shift - {1'b0, divisor};
        q_bit   = ~trial[N];
        // The kept value is always below the divisor, so bit N is never needed.
        r_next  = q_bit ? trial[N-1:0] : r_shift[N-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned divider: one restoring step per clock, N steps per result,
// with a one-cycle shortcut for a zero divisor.
module seq_divider
    import div_pkg::*;
#(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus,
    output state_t        state_dbg
);
    localparam logic [N-1:0]  DIV0_Q   = N'(DIV0_QUOTIENT(N));
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  r_reg;
    logic [N-1:0]  d_reg;
    logic [CW-1:0] cnt;
    logic [N-1:0]  r_step;
    logic          q_bit;
    logic          accept;
    logic          last_step;

    div_step #(.N(N)) u_step (
        .r        (r_reg),
        .next_bit (q_reg[N-1]),
        .divisor  (d_reg),
        .r_next   (r_step),
        .q_bit    (q_bit)
    );

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == CALC) && (cnt == '0);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = (|bus.divisor) ? CALC : DONE;
            CALC:    if (cnt == '0)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg           <= '0;
            r_reg           <= '0;
            d_reg           <= '0;
            cnt             <= '0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else if (accept) begin
            if (|bus.divisor) begin
                q_reg <= bus.dividend;
                d_reg <= bus.divisor;
                r_reg <= '0;
                cnt   <= CNT_LAST;
            end else begin
                bus.quotient    <= DIV0_Q;
                bus.remainder   <= bus.dividend;
                bus.div_by_zero <= 1'b1;
            end
        end else if (state == CALC) begin
            q_reg <= {q_reg[N-2:0], q_bit};
            r_reg <= r_step;
            if (last_step) begin
                bus.quotient    <= {q_reg[N-2:0], q_bit};
                bus.remainder   <= r_step;
                bus.div_by_zero <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases on an 8-bit instance and randomized
// operands on a 32-bit instance checked against a plain arithmetic model.
`timescale 1ns/1ps
module tb_seq_divider;
  import div_pkg::*;

  localparam int N8     = 8;
  localparam int N32    = 32;
  localparam int NRAND  = 1200;
  localparam int BUDGET = 200;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst8_n;
  logic rst32_n;

  seq_divider_if #(.N(N8))  bus8 ();
  seq_divider_if #(.N(N32)) bus32 ();
  state_t st8;
  state_t st32;

  seq_divider #(.N(N8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst8_n),
    .bus       (bus8),
    .state_dbg (st8)
  );

  seq_divider #(.N(N32)) u_dut32 (
    .clk       (clk),
    .rst_n     (rst32_n),
    .bus       (bus32),
    .state_dbg (st32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // reference model: {div_by_zero, quotient, remainder}
  function automatic logic [64:0] model32(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {1'b1, 32'hFFFF_FFFF, a};
    return {1'b0, a / b, a % b};
  endfunction

  // scoreboard for the 32-bit instance
  logic [64:0] exp_q[$];
  logic [63:0] op_q[$];
  time         acc_q[$];
  bit          seen32  = 1'b0;
  bit          mon32_on = 1'b0;

  always @(negedge clk) begin
    if (mon32_on) begin
      if (bus32.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r32_unexpected_valid q=%0h r=%0h", bus32.quotient, bus32.remainder);
        end else begin
          chk("r32_result", 96'({bus32.div_by_zero, bus32.quotient, bus32.remainder}), 96'(exp_q[0]));
          chk("r32_in_ready_busy", 96'(bus32.in_ready), 96'(0));
          if (!seen32) begin
            seen32 = 1'b1;
            chk("r32_latency", 96'($time - acc_q[0]),
                96'(((op_q[0][31:0] == 0) ? 0 : N32) * 10 + 5));
            if (op_q[0][31:0] != 0) begin
              chk("r32_invariant",
                  96'(64'(bus32.quotient) * 64'(op_q[0][31:0]) + 64'(bus32.remainder)),
                  96'(op_q[0][63:32]));
              chk("r32_rem_lt_div", 96'(bus32.remainder < op_q[0][31:0]), 96'(1));
            end
          end
          if (bus32.out_ready) begin
            void'(exp_q.pop_front());
            void'(op_q.pop_front());
            void'(acc_q.pop_front());
            seen32 = 1'b0;
          end
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        exp_q.push_back(model32(bus32.dividend, bus32.divisor));
        op_q.push_back({bus32.dividend, bus32.divisor});
        acc_q.push_back($time + 5);
      end
    end
  end

  initial begin
    bus32.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus32.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks: entered and left one time unit after a rising edge
  task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er, input logic ed, input int hold);
    int n;
    bus8.in_valid = 1'b1;
    bus8.dividend = a;
    bus8.divisor  = b;
    @(negedge clk);
    chk({name, "_in_ready"}, 96'(bus8.in_ready), 96'(1));
    @(posedge clk);
    #1;
    bus8.in_valid = (hold > 0);
    bus8.dividend = 8'($urandom);
    bus8.divisor  = 8'($urandom);
    n = 1;
    @(negedge clk);
    while (!bus8.out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 96'(n), 96'((b == 0) ? 1 : N8 + 1));
    chk({name, "_q"}, 96'(bus8.quotient), 96'(eq));
    chk({name, "_r"}, 96'(bus8.remainder), 96'(er));
    chk({name, "_dbz"}, 96'(bus8.div_by_zero), 96'(ed));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      bus8.dividend = 8'($urandom);
      bus8.divisor  = 8'($urandom);
      @(negedge clk);
      chk({name, "_hold_result"}, 96'({bus8.div_by_zero, bus8.quotient, bus8.remainder}), 96'({ed, eq, er}));
      chk({name, "_hold_in_ready"}, 96'(bus8.in_ready), 96'(0));
      chk({name, "_hold_out_valid"}, 96'(bus8.out_valid), 96'(1));
    end
    @(posedge clk);
    #1;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_drain_out_valid"}, 96'(bus8.out_valid), 96'(0));
    chk({name, "_drain_in_ready"}, 96'(bus8.in_ready), 96'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic directed8();
    op8("basic_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 0);
    op8("div0_55", 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1, 0);
    op8("edge_255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 0);
    op8("edge_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 0);
    op8("edge_0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 0);
    op8("edge_255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 0);
    op8("bp_77_5", 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, 5);
    // abort 200/13 with a one-edge reset on its 4th CALC edge
    bus8.in_valid = 1'b1;
    bus8.dividend = 8'd200;
    bus8.divisor  = 8'd13;
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    @(posedge clk);
    #1;
    rst8_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 96'(bus8.in_ready), 96'(1));
    chk("midrst_out_valid", 96'(bus8.out_valid), 96'(0));
    chk("midrst_outputs", 96'({bus8.div_by_zero, bus8.quotient, bus8.remainder}), 96'(0));
    @(posedge clk);
    #1;
    op8("after_rst_200_13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 0);
  endtask

  task automatic run32();
    logic [31:0] a;
    logic [31:0] b;
    int w;
    for (int i = 0; i < NRAND; i++) begin
      a = $urandom;
      case ($urandom_range(0, 15))
        0:       b = 32'd0;
        1, 2:    b = 32'd1;
        3, 4, 5: b = 32'($urandom_range(2, 15));
        6:       b = 32'hFFFF_FFFF;
        7:       begin a = 32'($urandom_range(0, 100)); b = 32'($urandom_range(101, 1000)); end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      bus32.in_valid = 1'b1;
      bus32.dividend = a;
      bus32.divisor  = b;
      w = 0;
      @(negedge clk);
      while (!bus32.in_ready && w < BUDGET) begin
        @(negedge clk);
        w++;
      end
      if (!bus32.in_ready) begin
        checks++;
        errors++;
        $display("FAIL r32_accept_timeout in_ready=%0b required=1", bus32.in_ready);
        break;
      end
      @(posedge clk);
      #1;
      bus32.in_valid = 1'b0;
      bus32.dividend = $urandom;
      bus32.divisor  = $urandom;
    end
    w = 0;
    while (exp_q.size() != 0 && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    chk("r32_drained", 96'(exp_q.size()), 96'(0));
  endtask

  initial begin
    rst8_n          = 1'b0;
    rst32_n         = 1'b0;
    bus8.in_valid   = 1'b0;
    bus8.dividend   = '0;
    bus8.divisor    = '0;
    bus8.out_ready  = 1'b0;
    bus32.in_valid  = 1'b0;
    bus32.dividend  = '0;
    bus32.divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst8_n  = 1'b1;
    rst32_n = 1'b1;
    @(negedge clk);
    chk("rst8_state", 96'(st8), 96'(IDLE));
    chk("rst8_in_ready", 96'(bus8.in_ready), 96'(1));
    chk("rst8_out_valid", 96'(bus8.out_valid), 96'(0));
    chk("rst8_outputs", 96'({bus8.div_by_zero, bus8.quotient, bus8.remainder}), 96'(0));
    chk("rst32_state", 96'(st32), 96'(IDLE));
    chk("rst32_outputs", 96'({bus32.out_valid, bus32.div_by_zero, bus32.quotient, bus32.remainder}), 96'(0));
    chk("model_100_7", 96'(model32(32'd100, 32'd7)), 96'({1'b0, 32'd14, 32'd2}));
    chk("model_55_0", 96'(model32(32'd55, 32'd0)), 96'({1'b1, 32'hFFFF_FFFF, 32'd55}));
    chk("model_5_9", 96'(model32(32'd5, 32'd9)), 96'({1'b0, 32'd0, 32'd5}));
    mon32_on = 1'b1;
    @(posedge clk);
    #1;
    fork
      directed8();
      run32();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
